// File: rtl/bcd_alu_pkg.sv
// Shared opcodes, FSM state encoding and digit check for the sequential BCD ALU.
package bcd_alu_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_PASS_A = 4'h2;
  localparam logic [3:0] OP_PASS_B = 4'h3;
  localparam logic [3:0] OP_MAX    = 4'h4;
  localparam logic [3:0] OP_MIN    = 4'h5;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CONV_IN  = 3'd1;
  localparam logic [2:0] ST_EXEC     = 3'd2;
  localparam logic [2:0] ST_CONV_OUT = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  function automatic logic digit_ok(input logic [3:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_alu_if.sv
// Operand/result handshake bundle between the operand registers, the BCD ALU and the display driver.
interface bcd_alu_if #(parameter int DIGITS = 8);
  localparam int RES_DIG = DIGITS + 1;

  logic                   in_valid;
  logic                   in_ready;
  logic [4*DIGITS-1:0]    a_bcd;
  logic [4*DIGITS-1:0]    b_bcd;
  logic [3:0]             opcode;
  logic                   out_valid;
  logic                   out_ready;
  logic [4*RES_DIG-1:0]   result;
  logic                   carry_out;
  logic                   negative;
  logic                   zero;
  logic                   illegal;
  logic                   err;

  modport master (
    output in_valid, a_bcd, b_bcd, opcode, out_ready,
    input  in_ready, out_valid, result, carry_out, negative, zero, illegal, err
  );

  modport slave (
    input  in_valid, a_bcd, b_bcd, opcode, out_ready,
    output in_ready, out_valid, result, carry_out, negative, zero, illegal, err
  );
endinterface

// File: rtl/bcd_dabble_seq.sv
// Sequential binary->BCD double-dabble: start loads the value, then one bit is shifted in per cycle.
module bcd_dabble_seq #(
  parameter int W  = 33,
  parameter int ND = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [W-1:0]    bin,
  output logic            busy,
  output logic            done,
  output logic [4*ND-1:0] bcd
);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]    sr_q, sr_d;
  logic [4*ND-1:0] bcd_q, bcd_d, adj;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < ND; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    sr_d   = sr_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (start) begin
      sr_d  = bin;
      bcd_d = '0;
      cnt_d = CW'(W);
    end else if (cnt_q != '0) begin
      bcd_d  = {adj[4*ND-2:0], sr_q[W-1]};
      sr_d   = sr_q << 1;
      cnt_d  = cnt_q - CW'(1);
      done_d = (cnt_q == CW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign busy = (cnt_q != '0);
  assign done = done_q;
  assign bcd  = bcd_q;
endmodule

// File: rtl/bcd_alu_seq.sv
// Multi-cycle BCD ALU: BCD->binary, one operation, binary->BCD, valid/ready on both sides.
// Build option BCD_ALU_ERRCHK_EN: flag non-decimal input nibbles and force a zero result.
//   state       | meaning
//   ST_IDLE     | in_ready=1, waiting for operands
//   ST_CONV_IN  | one BCD digit per operand per cycle, MS digit first
//   ST_EXEC     | single-cycle operation, flags captured, converter started
//   ST_CONV_OUT | double-dabble running
//   ST_DONE     | out_valid=1 until out_ready
module bcd_alu_seq
  import bcd_alu_pkg::*;
#(
  parameter int DIGITS  = 8,
  parameter int BIN_W   = 4*DIGITS,
  parameter int RES_DIG = DIGITS + 1
) (
  input  logic       clk,
  input  logic       rst,
  bcd_alu_if.slave   bus
);
  localparam int CW = $clog2(DIGITS);

  function automatic logic [BIN_W:0] pow10(input int n);
    logic [BIN_W:0] p;
    p    = '0;
    p[0] = 1'b1;
    for (int i = 0; i < n; i++) p = (p << 3) + (p << 1);
    return p;
  endfunction

  localparam logic [BIN_W:0] TEN_POW = pow10(DIGITS);

  logic [2:0]            state_q, state_d;
  logic [4*DIGITS-1:0]   a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic [3:0]            op_q, op_d;
  logic [BIN_W-1:0]      a_acc_q, a_acc_d, b_acc_q, b_acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  errin_q, errin_d;
  logic                  carry_p_q, carry_p_d, neg_p_q, neg_p_d, zero_p_q, zero_p_d;
  logic                  ill_p_q, ill_p_d, err_p_q, err_p_d;
  logic [4*RES_DIG-1:0]  result_q, result_d;
  logic                  carry_q, carry_d, neg_q, neg_d, zero_q, zero_d;
  logic                  ill_q, ill_d, err_q, err_d;

  logic [3:0]            a_dig, b_dig;
  logic [BIN_W:0]        a_ext, b_ext, ex_r;
  logic                  lt, ex_neg, ex_ill, ex_carry, ex_zero;
  logic                  dab_busy, dab_done;
  logic [4*RES_DIG-1:0]  dab_bcd;

  assign a_dig = a_sh_q[4*DIGITS-1 -: 4];
  assign b_dig = b_sh_q[4*DIGITS-1 -: 4];

  always_comb begin
    a_ext  = {1'b0, a_acc_q};
    b_ext  = {1'b0, b_acc_q};
    lt     = (a_acc_q < b_acc_q);
    ex_neg = 1'b0;
    ex_ill = 1'b0;
    case (op_q)
      OP_ADD:    ex_r = a_ext + b_ext;
      OP_SUB: begin
        ex_r   = lt ? (b_ext - a_ext) : (a_ext - b_ext);
        ex_neg = lt;
      end
      OP_PASS_A: ex_r = a_ext;
      OP_PASS_B: ex_r = b_ext;
      OP_MAX:    ex_r = lt ? b_ext : a_ext;
      OP_MIN:    ex_r = lt ? a_ext : b_ext;
      default: begin
        ex_r   = '0;
        ex_ill = 1'b1;
      end
    endcase
`ifdef BCD_ALU_ERRCHK_EN
    if (errin_q) begin
      ex_r   = '0;
      ex_neg = 1'b0;
    end
`endif
    ex_carry = (op_q == OP_ADD) && (ex_r >= TEN_POW);
    ex_zero  = (ex_r == '0);
  end

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    op_d      = op_q;
    a_acc_d   = a_acc_q;
    b_acc_d   = b_acc_q;
    cnt_d     = cnt_q;
    errin_d   = errin_q;
    carry_p_d = carry_p_q;
    neg_p_d   = neg_p_q;
    zero_p_d  = zero_p_q;
    ill_p_d   = ill_p_q;
    err_p_d   = err_p_q;
    result_d  = result_q;
    carry_d   = carry_q;
    neg_d     = neg_q;
    zero_d    = zero_q;
    ill_d     = ill_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_sh_d  = bus.a_bcd;
          b_sh_d  = bus.b_bcd;
          op_d    = bus.opcode;
          a_acc_d = '0;
          b_acc_d = '0;
          cnt_d   = CW'(DIGITS - 1);
          errin_d = 1'b0;
          state_d = ST_CONV_IN;
        end
      end
      ST_CONV_IN: begin
        // acc*10 as acc*8 + acc*2
        a_acc_d = (a_acc_q << 3) + (a_acc_q << 1) + BIN_W'(a_dig);
        b_acc_d = (b_acc_q << 3) + (b_acc_q << 1) + BIN_W'(b_dig);
        a_sh_d  = a_sh_q << 4;
        b_sh_d  = b_sh_q << 4;
`ifdef BCD_ALU_ERRCHK_EN
        errin_d = errin_q | ~digit_ok(a_dig) | ~digit_ok(b_dig);
`else
        errin_d = 1'b0;
`endif
        if (cnt_q == '0) state_d = ST_EXEC;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_EXEC: begin
        carry_p_d = ex_carry;
        neg_p_d   = ex_neg;
        zero_p_d  = ex_zero;
        ill_p_d   = ex_ill;
        err_p_d   = errin_q;
        state_d   = ST_CONV_OUT;
      end
      ST_CONV_OUT: begin
        if (dab_done && !dab_busy) begin
          result_d = dab_bcd;
          carry_d  = carry_p_q;
          neg_d    = neg_p_q;
          zero_d   = zero_p_q;
          ill_d    = ill_p_q;
          err_d    = err_p_q;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      op_q      <= '0;
      a_acc_q   <= '0;
      b_acc_q   <= '0;
      cnt_q     <= '0;
      errin_q   <= 1'b0;
      carry_p_q <= 1'b0;
      neg_p_q   <= 1'b0;
      zero_p_q  <= 1'b0;
      ill_p_q   <= 1'b0;
      err_p_q   <= 1'b0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      neg_q     <= 1'b0;
      zero_q    <= 1'b0;
      ill_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      op_q      <= op_d;
      a_acc_q   <= a_acc_d;
      b_acc_q   <= b_acc_d;
      cnt_q     <= cnt_d;
      errin_q   <= errin_d;
      carry_p_q <= carry_p_d;
      neg_p_q   <= neg_p_d;
      zero_p_q  <= zero_p_d;
      ill_p_q   <= ill_p_d;
      err_p_q   <= err_p_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
      neg_q     <= neg_d;
      zero_q    <= zero_d;
      ill_q     <= ill_d;
      err_q     <= err_d;
    end
  end

  bcd_dabble_seq #(.W(BIN_W + 1), .ND(RES_DIG)) u_dabble (
    .clk   (clk),
    .rst   (rst),
    .start (state_q == ST_EXEC),
    .bin   (ex_r),
    .busy  (dab_busy),
    .done  (dab_done),
    .bcd   (dab_bcd)
  );

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.carry_out = carry_q;
  assign bus.negative  = neg_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = ill_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_bcd_alu_seq.sv
// Self-checking bench for bcd_alu_seq (DIGITS=8): directed table, handshake/reset sequences, random jobs vs a numeric model.
module tb_bcd_alu_seq;
  localparam int DIGITS  = 8;
  localparam int RES_DIG = DIGITS + 1;
  localparam int LAT     = 43;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd_alu_if #(.DIGITS(DIGITS)) bus();
  bcd_alu_seq #(.DIGITS(DIGITS)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [35:0] res;
    logic        c, n, z, i, e;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic longint bcd_val(input logic [31:0] v);
    longint s = 0;
    longint w = 1;
    for (int k = 0; k < DIGITS; k++) begin
      s += longint'(v[4*k +: 4]) * w;
      w *= 10;
    end
    return s;
  endfunction

  function automatic logic [35:0] to_bcd(input longint x);
    logic [35:0] o = '0;
    for (int k = 0; k < RES_DIG; k++) begin
      o[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return o;
  endfunction

  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                       output logic [35:0] res, output logic c, output logic n,
                       output logic z, output logic i, output logic e);
    longint av = bcd_val(a);
    longint bv = bcd_val(b);
    longint r;
    e = 1'b0;
`ifdef BCD_ALU_ERRCHK_EN
    for (int k = 0; k < DIGITS; k++)
      if (a[4*k +: 4] > 4'd9 || b[4*k +: 4] > 4'd9) e = 1'b1;
`endif
    i = 1'b0;
    n = 1'b0;
    case (op)
      4'h0: r = av + bv;
      4'h1: begin r = (av < bv) ? bv - av : av - bv; n = (av < bv); end
      4'h2: r = av;
      4'h3: r = bv;
      4'h4: r = (av > bv) ? av : bv;
      4'h5: r = (av < bv) ? av : bv;
      default: begin r = 0; i = 1'b1; end
    endcase
    if (e) begin r = 0; n = 1'b0; end
    c   = (op == 4'h0) && (r >= 64'd100000000);
    z   = (r == 0);
    res = to_bcd(r);
  endtask

  task automatic drive_job(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    int t = 0;
    while (!bus.in_ready && t < 200) begin @(posedge clk); #1; t++; end
    chk("in_ready_wait", 64'(bus.in_ready), 64'd1);
    bus.a_bcd    = a;
    bus.b_bcd    = b;
    bus.opcode   = op;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("out_valid_wait", 64'(bus.out_valid), 64'd1);
  endtask

  task automatic check_out(input string nm, input logic [35:0] res, input logic c, input logic n,
                           input logic z, input logic i, input logic e);
    chk({nm, ".result"},   64'(bus.result),    64'(res));
    chk({nm, ".carry"},    64'(bus.carry_out), 64'(c));
    chk({nm, ".negative"}, 64'(bus.negative),  64'(n));
    chk({nm, ".zero"},     64'(bus.zero),      64'(z));
    chk({nm, ".illegal"},  64'(bus.illegal),   64'(i));
    chk({nm, ".err"},      64'(bus.err),       64'(e));
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("release.out_valid", 64'(bus.out_valid), 64'd0);
    chk("release.in_ready",  64'(bus.in_ready),  64'd1);
  endtask

  initial begin
    int lat;
    logic [31:0] ra, rb;
    logic [3:0]  rop;
    logic [35:0] eres, held;
    logic ec, en, ez, ei, ee;
    bit seen;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a_bcd     = '0;
    bus.b_bcd     = '0;
    bus.opcode    = '0;

    vecs[0] = '{32'h00000099, 32'h00000001, 4'h0, 36'h000000100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h99999999, 32'h00000001, 4'h0, 36'h100000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'h00000005, 32'h00000012, 4'h1, 36'h000000007, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{32'h00001234, 32'h00001234, 4'h1, 36'h000000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{32'h00001234, 32'h00005678, 4'hF, 36'h000000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{32'h00001234, 32'h00005678, 4'h4, 36'h000005678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{32'h00001234, 32'h00005678, 4'h5, 36'h000001234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{32'h99999999, 32'h99999999, 4'h0, 36'h199999998, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{32'h87654321, 32'h00000000, 4'h3, 36'h000000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`ifdef BCD_ALU_ERRCHK_EN
    vecs[9] = '{32'h0000000A, 32'h00000000, 4'h0, 36'h000000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    vecs[9] = '{32'h0000000A, 32'h00000000, 4'h0, 36'h000000010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

    repeat (3) @(posedge clk);
    #1;
    check_out("reset", 36'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.in_ready",  64'(bus.in_ready),  64'd1);
    chk("reset.out_valid", 64'(bus.out_valid), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 10; v++) begin
      drive_job(vecs[v].a, vecs[v].b, vecs[v].op);
      wait_out(lat);
      chk($sformatf("vec%0d.latency", v), 64'(lat), 64'(LAT));
      check_out($sformatf("vec%0d", v), vecs[v].res, vecs[v].c, vecs[v].n,
                vecs[v].z, vecs[v].i, vecs[v].e);
      release_out();
    end

    // back-pressure: result held, busy input ignored
    drive_job(32'h00004321, 32'h00001111, 4'h1);
    wait_out(lat);
    held = bus.result;
    chk("hold.first", 64'(held), 64'h000003210);
    for (int k = 0; k < 10; k++) begin
      bus.a_bcd    = 32'h00000777;
      bus.b_bcd    = 32'h00000001;
      bus.opcode   = 4'h0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("hold%0d.result", k),    64'(bus.result),    64'(held));
      chk($sformatf("hold%0d.in_ready", k),  64'(bus.in_ready),  64'd0);
      chk($sformatf("hold%0d.out_valid", k), 64'(bus.out_valid), 64'd1);
    end
    bus.in_valid = 1'b0;
    release_out();
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("hold.ignored_job", 64'(seen), 64'd0);

    // reset during CONV_OUT
    drive_job(32'h00000321, 32'h00000123, 4'h0);
    repeat (25) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst.in_ready",  64'(bus.in_ready),  64'd1);
    chk("midrst.out_valid", 64'(bus.out_valid), 64'd0);
    check_out("midrst", 36'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    drive_job(32'h00000321, 32'h00000123, 4'h0);
    wait_out(lat);
    chk("postrst.latency", 64'(lat), 64'(LAT));
    check_out("postrst", 36'h000000444, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    release_out();

    for (int j = 0; j < 40; j++) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (j % 8 == 7) begin
          ra[4*k +: 4] = 4'($urandom_range(15));
          rb[4*k +: 4] = 4'($urandom_range(15));
        end else begin
          ra[4*k +: 4] = 4'($urandom_range(9));
          rb[4*k +: 4] = 4'($urandom_range(9));
        end
      end
      if (j % 10 == 9) rb = ra;
      rop = (j % 13 == 12) ? 4'hF : 4'($urandom_range(7));
      model(ra, rb, rop, eres, ec, en, ez, ei, ee);
      drive_job(ra, rb, rop);
      wait_out(lat);
      check_out($sformatf("rnd%0d(%h,%h,%h)", j, ra, rb, rop), eres, ec, en, ez, ei, ee);
      release_out();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
